// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / data-memory controller.
package pipe_ctrl_pkg;

  // Data-memory access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // x0 is hardwired to zero and is never a forwarding source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default number of WAIT cycles before an access is abandoned.
  localparam int TIMEOUT_DEFAULT = 16;

  // True when the MW result must bypass the register file for one DE operand.
  function automatic logic fwd_hit(input logic       mw_valid,
                                   input logic       mw_reg_wr,
                                   input logic [4:0] mw_waddr,
                                   input logic       de_use,
                                   input logic [4:0] de_rs);
    return mw_valid & mw_reg_wr & (mw_waddr != REG_ZERO) & de_use & (de_rs == mw_waddr);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-control and data-memory handshake bundle between the datapath and the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             mw_valid;
  logic             mw_mem_rd;
  logic             mw_mem_wr;
  logic             mw_reg_wr;
  logic [4:0]       mw_waddr;
  logic [4:0]       de_rs1;
  logic [4:0]       de_rs2;
  logic             de_use_rs1;
  logic             de_use_rs2;
  logic             br_taken;
  logic             dmem_ack;
  logic             dmem_err;
  logic             err_clr;
  logic             dmem_req;
  logic             dmem_we;
  logic             stall_f;
  logic             stall_de;
  logic             stall_mw;
  logic             flush_de;
  logic             fwd_a;
  logic             fwd_b;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;

  // Controller side.
  modport master (
    input  mw_valid, mw_mem_rd, mw_mem_wr, mw_reg_wr, mw_waddr,
    input  de_rs1, de_rs2, de_use_rs1, de_use_rs2, br_taken,
    input  dmem_ack, dmem_err, err_clr,
    output dmem_req, dmem_we, stall_f, stall_de, stall_mw, flush_de,
    output fwd_a, fwd_b, bus_err, stall_cnt
  );

  // Datapath / memory side.
  modport slave (
    output mw_valid, mw_mem_rd, mw_mem_wr, mw_reg_wr, mw_waddr,
    output de_rs1, de_rs2, de_use_rs1, de_use_rs2, br_taken,
    output dmem_ack, dmem_err, err_clr,
    input  dmem_req, dmem_we, stall_f, stall_de, stall_mw, flush_de,
    input  fwd_a, fwd_b, bus_err, stall_cnt
  );
endinterface

// File: rtl/dmem_seq.sv
// Data-memory access sequencer: IDLE/WAIT/DONE FSM, timeout watchdog and sticky error flag.
module dmem_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic mem_wr_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic err_clr_i,
  output logic dmem_req_o,
  output logic dmem_we_o,
  output logic stall_o,
  output logic bus_err_o
);

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       req_q, req_d;
  logic       bus_err_q, bus_err_d;
  logic       err_set;

  // Next-state, request, watchdog and stall decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    tcnt_d  = tcnt_q;
    req_d   = 1'b0;
    stall_o = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op_i) begin
          stall_o = 1'b1;
          state_d = WAIT;
          tcnt_d  = 8'd0;
          req_d   = 1'b1;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        tcnt_d  = tcnt_q + 8'd1;
        if (ack_i) begin
          state_d = DONE;
          err_set = err_i;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = DONE;
          err_set = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Set has priority over clear.
    bus_err_d = err_set | (bus_err_q & ~err_clr_i);
  end

  // State, watchdog, request and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      tcnt_q    <= 8'd0;
      req_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      req_q     <= req_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign dmem_req_o = req_q;
  assign dmem_we_o  = req_q & mem_wr_i;
  assign bus_err_o  = bus_err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F | DE | MW pipeline: stalls, flush, forwarding and stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.master bus
);

  logic             mem_op;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign mem_op = bus.mw_valid & (bus.mw_mem_rd | bus.mw_mem_wr);

  dmem_seq #(
    .TIMEOUT (TIMEOUT)
  ) u_dmem_seq (
    .clk        (clk),
    .rst        (rst),
    .mem_op_i   (mem_op),
    .mem_wr_i   (bus.mw_mem_wr),
    .ack_i      (bus.dmem_ack),
    .err_i      (bus.dmem_err),
    .err_clr_i  (bus.err_clr),
    .dmem_req_o (bus.dmem_req),
    .dmem_we_o  (bus.dmem_we),
    .stall_o    (stall),
    .bus_err_o  (bus.bus_err)
  );

  // The whole front of the pipeline freezes together while MW waits on memory.
  assign bus.stall_f  = stall;
  assign bus.stall_de = stall;
  assign bus.stall_mw = stall;

  // A taken branch held in a stalled DE flushes only once the stall releases.
  assign bus.flush_de = bus.br_taken & ~stall;

  assign bus.fwd_a = fwd_hit(bus.mw_valid, bus.mw_reg_wr, bus.mw_waddr, bus.de_use_rs1, bus.de_rs1);
  assign bus.fwd_b = fwd_hit(bus.mw_valid, bus.mw_reg_wr, bus.mw_waddr, bus.de_use_rs2, bus.de_rs2);

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: behavioural access model compared every cycle, plus directed scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int TO    = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  // Behavioural model: is an access outstanding, how many WAIT cycles it has used,
  // whether the release cycle is next, the error flag and the stall count.
  bit     m_busy, m_release, m_err;
  int     m_waited;
  longint m_cnt;

  // Observation counters for directed scenarios.
  int obs_stall, obs_req, obs_we, obs_fwd_a, obs_flush;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic clr_obs();
    obs_stall = 0; obs_req = 0; obs_we = 0; obs_fwd_a = 0; obs_flush = 0;
  endtask

  function automatic bit mem_op_in();
    return bus.mw_valid & (bus.mw_mem_rd | bus.mw_mem_wr);
  endfunction

  function automatic bit exp_stall();
    return m_busy | (!m_release & mem_op_in());
  endfunction

  function automatic bit exp_fwd(input logic use_rs, input logic [4:0] rs);
    return bus.mw_valid & bus.mw_reg_wr & (bus.mw_waddr != 5'd0) & use_rs & (rs == bus.mw_waddr);
  endfunction

  // One clock: compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit st, ack_now, err_now, clr_now, timed_out, err_set;
    @(negedge clk);
    st = exp_stall();
    check("stall_f",   bus.stall_f,   st);
    check("stall_de",  bus.stall_de,  st);
    check("stall_mw",  bus.stall_mw,  st);
    check("dmem_req",  bus.dmem_req,  m_busy);
    check("dmem_we",   bus.dmem_we,   m_busy & bus.mw_mem_wr);
    check("flush_de",  bus.flush_de,  bus.br_taken & ~st);
    check("fwd_a",     bus.fwd_a,     exp_fwd(bus.de_use_rs1, bus.de_rs1));
    check("fwd_b",     bus.fwd_b,     exp_fwd(bus.de_use_rs2, bus.de_rs2));
    check("bus_err",   bus.bus_err,   m_err);
    check("stall_cnt", bus.stall_cnt, m_cnt);
    obs_stall += int'(bus.stall_mw);
    obs_req   += int'(bus.dmem_req);
    obs_we    += int'(bus.dmem_we);
    obs_fwd_a += int'(bus.fwd_a);
    obs_flush += int'(bus.flush_de);
    ack_now = bus.dmem_ack; err_now = bus.dmem_err; clr_now = bus.err_clr;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_release = 0; m_err = 0; m_waited = 0; m_cnt = 0;
    end else begin
      err_set = 0;
      if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_busy) begin
        m_waited++;
        timed_out = !ack_now && (m_waited == TO);
        if (ack_now || timed_out) begin
          m_busy    = 0;
          m_release = 1;
          err_set   = (ack_now & err_now) | timed_out;
        end
      end else if (m_release) begin
        m_release = 0;
      end else if (mem_op_in()) begin
        m_busy   = 1;
        m_waited = 0;
      end
      m_err = err_set ? 1'b1 : (clr_now ? 1'b0 : m_err);
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.mw_valid = 0; bus.mw_mem_rd = 0; bus.mw_mem_wr = 0; bus.mw_reg_wr = 0; bus.mw_waddr = 0;
    bus.de_rs1 = 0; bus.de_rs2 = 0; bus.de_use_rs1 = 0; bus.de_use_rs2 = 0; bus.br_taken = 0;
    bus.dmem_ack = 0; bus.dmem_err = 0; bus.err_clr = 0;
  endtask

  task automatic set_mw(input bit v, input bit rd, input bit wr, input bit rw, input logic [4:0] wa);
    bus.mw_valid = v; bus.mw_mem_rd = rd; bus.mw_mem_wr = wr; bus.mw_reg_wr = rw; bus.mw_waddr = wa;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    int budget;
    idle_inputs();
    rst = 1;
    m_busy = 0; m_release = 0; m_err = 0; m_waited = 0; m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset values, held for a couple of cycles.
    cycle();
    check("rst_req", bus.dmem_req, 0);
    check("rst_cnt", bus.stall_cnt, 0);
    rst = 0;
    cycle();

    // Load to x5, ack on the first WAIT cycle, DE reads x5 on rs1.
    do_reset();
    clr_obs();
    set_mw(1, 1, 0, 1, 5'd5);
    bus.de_rs1 = 5'd5; bus.de_use_rs1 = 1;
    cycle();
    bus.dmem_ack = 1;
    cycle();
    bus.dmem_ack = 0;
    cycle();
    check("ld_stall_cycles", obs_stall, 2);
    check("ld_req_cycles",   obs_req,   1);
    check("ld_we_cycles",    obs_we,    0);
    check("ld_fwd_a_cycles", obs_fwd_a, 3);
    check("ld_stall_cnt",    bus.stall_cnt, 2);
    idle_inputs();
    cycle();

    // Store, ack on the 4th WAIT cycle.
    do_reset();
    clr_obs();
    set_mw(1, 0, 1, 0, 5'd7);
    bus.de_rs1 = 5'd7; bus.de_use_rs1 = 1;
    cycle();
    repeat (3) cycle();
    bus.dmem_ack = 1;
    cycle();
    bus.dmem_ack = 0;
    cycle();
    check("st_req_cycles",   obs_req,   4);
    check("st_we_cycles",    obs_we,    4);
    check("st_stall_cycles", obs_stall, 5);
    check("st_fwd_a_cycles", obs_fwd_a, 0);
    check("st_stall_cnt",    bus.stall_cnt, 5);
    idle_inputs();
    cycle();

    // No ack: watchdog abandons the access after TIMEOUT WAIT cycles.
    do_reset();
    clr_obs();
    set_mw(1, 1, 0, 1, 5'd3);
    cycle();
    budget = 0;
    while (bus.dmem_req && budget < 40) begin
      cycle();
      budget++;
    end
    check("to_req_cycles", obs_req, 16);
    check("to_bus_err",    bus.bus_err, 1);
    check("to_released",   bus.stall_mw, 0);
    cycle();
    idle_inputs();
    bus.err_clr = 1;
    cycle();
    bus.err_clr = 0;
    check("err_cleared", bus.bus_err, 0);
    // New error response while err_clr is held: set wins.
    set_mw(1, 1, 0, 0, 5'd0);
    cycle();
    bus.dmem_ack = 1; bus.dmem_err = 1; bus.err_clr = 1;
    cycle();
    bus.dmem_ack = 0; bus.dmem_err = 0; bus.err_clr = 0;
    check("err_set_wins", bus.bus_err, 1);
    cycle();
    idle_inputs();
    cycle();

    // Taken branch held in DE while a load waits: flush only in the release cycle.
    do_reset();
    clr_obs();
    set_mw(1, 1, 0, 1, 5'd9);
    bus.br_taken = 1;
    cycle();
    cycle();
    bus.dmem_ack = 1;
    cycle();
    bus.dmem_ack = 0;
    check("br_flush_during_stall", obs_flush, 0);
    cycle();
    check("br_flush_total", obs_flush, 1);
    idle_inputs();
    cycle();

    // ALU op writing x0 never forwards and never stalls.
    do_reset();
    clr_obs();
    set_mw(1, 0, 0, 1, 5'd0);
    bus.de_rs1 = 5'd0; bus.de_use_rs1 = 1;
    cycle();
    check("x0_fwd_a", obs_fwd_a, 0);
    check("x0_stall", obs_stall, 0);

    // Reset during WAIT: request drops on the reset edge and a late ack is ignored.
    do_reset();
    set_mw(1, 1, 0, 1, 5'd4);
    cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    idle_inputs();
    check("rst_wait_req", bus.dmem_req, 0);
    bus.dmem_ack = 1;
    cycle();
    bus.dmem_ack = 0;
    check("late_ack_req",   bus.dmem_req, 0);
    check("late_ack_stall", bus.stall_mw, 0);
    cycle();

    // Randomised traffic; MW contents only change when the pipeline is not stalled.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!exp_stall()) begin
        int kind;
        kind = int'($urandom_range(0, 3));
        set_mw(1'($urandom_range(0, 1)), kind == 1, kind == 2, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)));
      end
      bus.de_rs1     = 5'($urandom_range(0, 3));
      bus.de_rs2     = 5'($urandom_range(0, 3));
      bus.de_use_rs1 = 1'($urandom_range(0, 1));
      bus.de_use_rs2 = 1'($urandom_range(0, 1));
      bus.br_taken   = ($urandom_range(0, 3) == 0);
      bus.dmem_ack   = ($urandom_range(0, 9) < 2);
      bus.dmem_err   = ($urandom_range(0, 3) == 0);
      bus.err_clr    = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and memory-sequencing controller for the 3-stage pipeline (Fetch | Decode/Execute | Memory/Writeback). It produces the stall, flush and forwarding controls for the pipeline registers, including `stall_mw` for the MW register. It sequences variable-latency data-memory accesses through a req/ack handshake and bounds each access with a timeout watchdog. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum WAIT cycles before an access is abandoned; legal range 2..255.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mw_valid` in 1: MW register holds a valid instruction.
- `mw_mem_rd`, `mw_mem_wr` in 1 each: MW instruction is a load / store; never both.
- `mw_reg_wr` in 1: MW instruction writes the register file.
- `mw_waddr` in 5: MW destination register.
- `de_rs1`, `de_rs2` in 5 each: DE source registers.
- `de_use_rs1`, `de_use_rs2` in 1 each: DE instruction reads rs1 / rs2.
- `br_taken` in 1: taken branch or jump resolved in DE.
- `dmem_ack` in 1: data memory completes the access.
- `dmem_err` in 1: error response; qualified by `dmem_ack`.
- `err_clr` in 1: clears `bus_err`.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: write request, valid with `dmem_req`.
- `stall_f`, `stall_de`, `stall_mw` out 1 each: hold PC / F-DE register / MW register.
- `flush_de` out 1: zero the F-DE register.
- `fwd_a`, `fwd_b` out 1 each: select the MW ALU/load result for DE operand A / B.
- `bus_err` out 1: sticky error flag.
- `stall_cnt` out CNT_W: number of stalled cycles.

## Operation
- The FSM has three states: IDLE, WAIT and DONE. Reset state is IDLE.
- **IDLE**
  - When `mw_valid & (mw_mem_rd | mw_mem_wr)`, the next state is WAIT. The stall is asserted in this cycle.
  - Otherwise the FSM stays in IDLE.
- **WAIT**
  - `dmem_req`=1 and `dmem_we`=`mw_mem_wr`.
  - On `dmem_ack`, the next state is DONE. If `dmem_err` is also high, `bus_err` is set.
  - When the timeout counter reaches `TIMEOUT`-1 without an ack, the next state is DONE and `bus_err` is set.
  - The timeout counter clears on entry to WAIT and counts each WAIT cycle.
- **DONE**
  - Stall is released for one cycle and load data is valid.
  - The next state is always IDLE, so the following MW instruction is evaluated fresh.
- **Stall:** `stall_f`=`stall_de`=`stall_mw`=1 in IDLE-with-mem-op and in WAIT; 0 otherwise.
- **Forwarding (combinational, FSM-independent):**
  - `fwd_a` = `mw_valid & mw_reg_wr & (mw_waddr!=0) & de_use_rs1 & (de_rs1==mw_waddr)`.
  - `fwd_b` is the same, using rs2.
  - For loads, DE is stalled until DONE, so forwarded data is consumed only once valid.
- **Flush:** `flush_de` = `br_taken & ~stall_de`. A branch held in a stalled DE flushes on the cycle the stall releases.
- **`bus_err`:**
  - Set on an error response or a timeout.
  - Cleared by `err_clr`. If set and clear occur in the same cycle, set wins.
  - The error does not block the pipeline.
- **`stall_cnt`:** increments each cycle `stall_mw`=1 and saturates at all-ones.
- **Stray ack:** `dmem_ack` outside WAIT is ignored.

## Timing
- **Reset values:** state IDLE, `dmem_req`=0, `bus_err`=0, `stall_cnt`=0, timeout counter 0.
  - The stall, flush and forwarding outputs are combinational; with `mw_valid`=0 and `br_taken`=0 they are 0.
- **Memory op with ack on the first WAIT cycle:** 3 cycles in MW (IDLE, WAIT, DONE) and 2 stall cycles.
  - Each extra cycle of ack latency adds one stall cycle.
- **Timeout:** the access occupies exactly `TIMEOUT` WAIT cycles, then DONE.
- **`dmem_req` timing:** registered, rising on the WAIT entry edge. It drops on the edge following ack, timeout or `rst`.
- **Reset mid-access:** FSM returns to IDLE and `dmem_req` deasserts on the reset edge.
  - An ack arriving after reset is ignored.
- **Back-to-back memory ops:** DONE→IDLE→WAIT, with no overlap of requests.

## Structure
- **Shared package `pipe_ctrl_pkg`:**
  - FSM state enum `mem_state_e` (IDLE, WAIT, DONE).
  - `REG_ZERO` constant.
  - Default `TIMEOUT` value.
- **Sub-module `dmem_seq`:** FSM, timeout counter and `bus_err` logic.
- **Top level:** forwarding, flush and stall counter.

## Test plan
- **Load to x5, ack on first WAIT cycle, DE uses rs1=x5:**
  - Stall high for 2 cycles; `dmem_req` high for 1 cycle with `dmem_we`=0.
  - `fwd_a`=1 throughout; `stall_cnt`=2.
- **Store, ack after 4 WAIT cycles:** `dmem_req`/`dmem_we` high for 4 cycles; stall for 5 cycles; no forwarding.
- **No ack, `TIMEOUT`=16:** exactly 16 WAIT cycles, then DONE; `bus_err`=1.
  - `err_clr` asserted in the same cycle as a new error leaves `bus_err`=1.
- **`br_taken` while a load is waiting:**
  - `flush_de`=0 during the stall.
  - `flush_de`=1 in the DONE cycle only.
- **ALU op writing x0, DE rs1=x0 with `de_use_rs1`=1:** `fwd_a`=0 and no stall.
  - Separately, `rst` asserted in WAIT: `dmem_req`=0 next cycle, and a subsequent ack causes no state change.
